ps2_keypad_rx: RTL and testbench
================================

# ps2_keypad_rx

Parametrised PS/2 keyboard receiver and keypad decoder for the calculator front end. It samples the PS/2 clock and data lines on a divided tick and assembles 11-bit frames with start, parity and stop checks. It tracks the `E0` (extended) and `F0` (break) prefix bytes, maps keypad scan codes to 4-bit key tokens, and buffers the tokens in a FIFO. The FIFO drains through a valid/ready handshake to the ALU input sequencer.

## Interface
Parameters:
- `CLK_DIV`, default 250: `CLK` cycles per sample tick; minimum 2.
- `TIMEOUT_TICKS`, default 4000: ticks without a falling edge that abort a partial frame.
- `FIFO_DEPTH`, default 4: token FIFO entries; must be a power of 2, minimum 2.

Ports:
- `CLK` in 1: system clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `PS2_CLK` in 1: keyboard clock, asynchronous to `CLK`.
- `PS2_DATA` in 1: keyboard data, asynchronous to `CLK`.
- `key_valid` out 1: FIFO head is valid.
- `key_ready` in 1: consumer accepts the head token.
- `key_code` out 4: token code. 0–9 are digits, 10 is +, 11 is −, 12 is *, 13 is /, 14 is Enter, 15 is Esc.
- `key_raw` out 8: scan code of the head token.
- `key_ext` out 1: head token was prefixed by `E0`.
- `key_release` out 1: head token is a break event.
- `frame_err` out 1: one-cycle pulse when a frame is discarded for a bad start, parity or stop bit.
- `overflow` out 1: one-cycle pulse when a token is dropped because the FIFO is full.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: occupancy.

## Operation
- `PS2_CLK` and `PS2_DATA` each pass through a 2-FF synchroniser.
- Tick counter runs 0..CLK_DIV−1. `tick` is high for one cycle at wrap.
- On each tick the previous synchronised `PS2_CLK` is stored. A falling edge is previous = 1 and current = 0.
- Frame FSM:
  - IDLE → SHIFT on the first falling edge.
  - SHIFT shifts `PS2_DATA` in LSB-first and increments a bit count.
  - After the 11th edge, SHIFT → CHECK.
  - CHECK is one cycle and then returns to IDLE. The frame is valid when start = 0, stop = 1 and data^parity has odd parity; a valid frame emits its byte. An invalid frame pulses `frame_err` and emits nothing.
- Timeout: in SHIFT, a tick counter counts ticks since the last edge. Reaching `TIMEOUT_TICKS` returns the FSM to IDLE, discards the frame and does not pulse `frame_err`.
- Prefix decoder, applied to each emitted byte:
  - `E0` sets `ext`; `F0` sets `brk`. Neither produces a token.
  - Any other byte is looked up in the table, then `ext` and `brk` are cleared.
- Lookup table:
  - 70→0, 69→1, 72→2, 7A→3, 6B→4, 73→5, 74→6, 6C→7, 75→8, 7D→9.
  - 79→10, 7B→11, 7C→12, 4A→13, 5A→14, 76→15.
  - A table hit is independent of `ext`.
  - Unmapped bytes produce no token but still clear the flags.
- FIFO: show-ahead.
  - `key_valid` = !empty.
  - A pop occurs when `key_valid && key_ready`.
  - A push when full drops the new token and pulses `overflow`.
  - A simultaneous push and pop when full is accepted with no overflow.
  - A pop when empty is ignored.
- Reset: all FSMs go to IDLE, counters and flags clear, FIFO empties, and every output is 0.
  - Reset mid-frame discards the partial frame and any pending prefix.

## Timing
- A token becomes visible on `key_valid` 3 `CLK` cycles after the tick that samples the 11th falling edge:
  - +1: CHECK
  - +2: decode and push
  - +3: registered visible
- `frame_err` pulses in the CHECK cycle.
- `overflow` pulses in the push cycle.
- `fifo_level` updates the cycle after the push or pop.
- A consumer holding `key_ready` = 1 can pop one token per `CLK` cycle.
- `key_code`, `key_raw`, `key_ext` and `key_release` remain stable while `key_valid` is high and no pop has occurred.

## Configuration
- `PS2_BREAK_EVENTS_EN` defined:
  - The byte after `F0` is pushed as a token with `key_release` = 1.
- `PS2_BREAK_EVENTS_EN` undefined:
  - The byte after `F0` is consumed, clears the flags, and produces no token.
  - `key_release` is tied to 0.

## Structure
- `ps2_pkg` holds:
  - a `key_code_t` enum (4-bit)
  - scan code constants (`SC_*`, `SC_EXT` = 8'hE0, `SC_BREAK` = 8'hF0)
  - a packed `key_token_t` {raw, code, ext, release}
  - the frame FSM state enum
- Sub-module `ps2_token_fifo` is parametrised by `FIFO_DEPTH` and stores `key_token_t`.

## Test plan
Directed scenarios at `CLK_DIV` = 4, `TIMEOUT_TICKS` = 20, `FIFO_DEPTH` = 4:
- Frame 0x69 with correct parity → `key_code` = 1, `key_raw` = 69, `key_ext` = 0. `key_valid` rises 3 cycles after the 11th-edge tick.
- Frame 0x72 with the parity bit flipped → `frame_err` pulses for 1 cycle, no token. The next frame 0x7A → `key_code` = 3.
- Bytes E0, 5A → `key_code` = 14, `key_ext` = 1. Then F0, 69:
  - with `PS2_BREAK_EVENTS_EN`: a token with code 1 and release = 1
  - without it: no token, `fifo_level` unchanged
- `key_ready` = 0 and keys 1, 2, 3, 4, 5 sent → `fifo_level` = 4, exactly one `overflow` pulse. Raising `key_ready` pops 1, 2, 3, 4 on consecutive cycles.
- 5 bits of a frame followed by 25 ticks of idle → no token and no `frame_err`. A following full 0x70 frame → `key_code` = 0.
- `RST_N` asserted after the 6th bit of a frame, with 2 tokens queued → all outputs 0, `fifo_level` = 0. The next clean 0x76 frame → `key_code` = 15.

Source files
------------

// File: rtl/ps2_keypad_rx_pkg.sv
//------------------------------------------------------------------------------
// Module   : ps2_pkg
// Brief    : Shared types, scan codes and keypad lookup for the PS/2 receiver.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;

    typedef enum logic [3:0] {
        KEY_0     = 4'd0,
        KEY_1     = 4'd1,
        KEY_2     = 4'd2,
        KEY_3     = 4'd3,
        KEY_4     = 4'd4,
        KEY_5     = 4'd5,
        KEY_6     = 4'd6,
        KEY_7     = 4'd7,
        KEY_8     = 4'd8,
        KEY_9     = 4'd9,
        KEY_ADD   = 4'd10,
        KEY_SUB   = 4'd11,
        KEY_MUL   = 4'd12,
        KEY_DIV   = 4'd13,
        KEY_ENTER = 4'd14,
        KEY_ESC   = 4'd15
    } key_code_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_0     = 8'h70;
    localparam logic [7:0] SC_1     = 8'h69;
    localparam logic [7:0] SC_2     = 8'h72;
    localparam logic [7:0] SC_3     = 8'h7A;
    localparam logic [7:0] SC_4     = 8'h6B;
    localparam logic [7:0] SC_5     = 8'h73;
    localparam logic [7:0] SC_6     = 8'h74;
    localparam logic [7:0] SC_7     = 8'h6C;
    localparam logic [7:0] SC_8     = 8'h75;
    localparam logic [7:0] SC_9     = 8'h7D;
    localparam logic [7:0] SC_ADD   = 8'h79;
    localparam logic [7:0] SC_SUB   = 8'h7B;
    localparam logic [7:0] SC_MUL   = 8'h7C;
    localparam logic [7:0] SC_DIV   = 8'h4A;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef struct packed {
        logic [7:0] raw;
        key_code_t  code;
        logic       ext;
        logic       is_release;
    } key_token_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } frame_state_t;

    typedef struct packed {
        logic      hit;
        key_code_t code;
    } scan_lookup_t;

    function automatic scan_lookup_t lookup_scan(input logic [7:0] sc);
        scan_lookup_t r;
        r.hit  = 1'b1;
        r.code = KEY_0;
        case (sc)
            SC_0:     r.code = KEY_0;
            SC_1:     r.code = KEY_1;
            SC_2:     r.code = KEY_2;
            SC_3:     r.code = KEY_3;
            SC_4:     r.code = KEY_4;
            SC_5:     r.code = KEY_5;
            SC_6:     r.code = KEY_6;
            SC_7:     r.code = KEY_7;
            SC_8:     r.code = KEY_8;
            SC_9:     r.code = KEY_9;
            SC_ADD:   r.code = KEY_ADD;
            SC_SUB:   r.code = KEY_SUB;
            SC_MUL:   r.code = KEY_MUL;
            SC_DIV:   r.code = KEY_DIV;
            SC_ENTER: r.code = KEY_ENTER;
            SC_ESC:   r.code = KEY_ESC;
            default:  r.hit  = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_keypad_rx_fifo.sv
//------------------------------------------------------------------------------
// Module   : ps2_token_fifo
// Brief    : Show-ahead token FIFO; a push into a full FIFO is dropped unless a
//            pop happens in the same cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_token_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        i_push,
    input  key_token_t                  i_token,
    input  logic                        i_pop,
    output logic                        o_valid,
    output key_token_t                  o_token,
    output logic                        o_overflow,
    output logic [$clog2(FIFO_DEPTH):0] o_level
);

    localparam int              c_AW   = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(FIFO_DEPTH);

    key_token_t        r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL);
    assign w_pop      = i_pop && !w_empty;
    // A pop frees the slot in the same cycle, so full + pop still accepts.
    assign w_push     = i_push && (!w_full || w_pop);
    assign o_overflow = i_push && w_full && !w_pop;
    assign o_valid    = !w_empty;
    assign o_token    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level    = r_count;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= i_token;
    end

endmodule

`default_nettype wire

// File: rtl/ps2_keypad_rx.sv
//------------------------------------------------------------------------------
// Module   : ps2_keypad_rx
// Brief    : PS/2 frame receiver, E0/F0 prefix decoder and keypad token FIFO.
//            Option macro: PS2_BREAK_EVENTS_EN (queue break events as tokens).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_keypad_rx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV       = 250,
    parameter int TIMEOUT_TICKS = 4000,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        PS2_CLK,
    input  logic                        PS2_DATA,
    output logic                        key_valid,
    input  logic                        key_ready,
    output logic [3:0]                  key_code,
    output logic [7:0]                  key_raw,
    output logic                        key_ext,
    output logic                        key_release,
    output logic                        frame_err,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int                 c_DIV_W  = $clog2(CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(CLK_DIV - 1);
    localparam int                 c_TO_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [c_TO_W-1:0]  c_TO_MAX = c_TO_W'(TIMEOUT_TICKS - 1);

    logic [1:0]          r_clk_sync;
    logic [1:0]          r_data_sync;
    logic                r_clk_prev;
    logic [c_DIV_W-1:0]  r_div_cnt;
    logic                w_tick;
    logic                w_fall;
    frame_state_t        r_state;
    frame_state_t        w_state_next;
    logic [10:0]         r_shift;
    logic [3:0]          r_bit_cnt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                w_frame_ok;
    logic [7:0]          r_byte;
    logic                r_byte_valid;
    logic                r_ext;
    logic                r_brk;
    logic                w_ext_next;
    logic                w_brk_next;
    logic                w_push;
    scan_lookup_t        w_lookup;
    key_token_t          w_tok;
    key_token_t          w_head;

    assign w_tick = (r_div_cnt == c_DIV_MAX);
    assign w_fall = r_clk_prev && !r_clk_sync[1];
    // Frame layout after 11 LSB-first shifts: [0] start, [8:1] data, [9] parity, [10] stop.
    assign w_frame_ok = !r_shift[0] && r_shift[10] && (^r_shift[9:1]);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
            r_div_cnt   <= '0;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], PS2_CLK};
            r_data_sync <= {r_data_sync[0], PS2_DATA};
            r_div_cnt   <= w_tick ? '0 : r_div_cnt + c_DIV_W'(1);
            if (w_tick) r_clk_prev <= r_clk_sync[1];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        frame_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && w_fall) w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_tick) begin
                    if (w_fall) begin
                        if (r_bit_cnt == 4'd10) w_state_next = ST_CHECK;
                    end else if (r_to_cnt == c_TO_MAX) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_CHECK: begin
                w_state_next = ST_IDLE;
                frame_err    = !w_frame_ok;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_to_cnt     <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            if (w_tick && w_fall && (r_state != ST_CHECK)) begin
                r_shift   <= {r_data_sync[1], r_shift[10:1]};
                r_bit_cnt <= (r_state == ST_IDLE) ? 4'd1 : r_bit_cnt + 4'd1;
            end
            if (r_state != ST_SHIFT) r_to_cnt <= '0;
            else if (w_tick)         r_to_cnt <= w_fall ? '0 : r_to_cnt + c_TO_W'(1);
            r_byte       <= r_shift[8:1];
            r_byte_valid <= (r_state == ST_CHECK) && w_frame_ok;
        end
    end

    always_comb begin
        w_ext_next = r_ext;
        w_brk_next = r_brk;
        w_push     = 1'b0;
        w_lookup   = lookup_scan(r_byte);
        w_tok.raw  = r_byte;
        w_tok.code = w_lookup.code;
        w_tok.ext  = r_ext;
`ifdef PS2_BREAK_EVENTS_EN
        w_tok.is_release = r_brk;
`else
        w_tok.is_release = 1'b0;
`endif
        if (r_byte_valid) begin
            if (r_byte == SC_EXT) begin
                w_ext_next = 1'b1;
            end else if (r_byte == SC_BREAK) begin
                w_brk_next = 1'b1;
            end else begin
                w_ext_next = 1'b0;
                w_brk_next = 1'b0;
`ifdef PS2_BREAK_EVENTS_EN
                w_push = w_lookup.hit;
`else
                w_push = w_lookup.hit && !r_brk;
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else begin
            r_ext <= w_ext_next;
            r_brk <= w_brk_next;
        end
    end

    ps2_token_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .i_push     (w_push),
        .i_token    (w_tok),
        .i_pop      (key_ready),
        .o_valid    (key_valid),
        .o_token    (w_head),
        .o_overflow (overflow),
        .o_level    (fifo_level)
    );

    assign key_code    = w_head.code;
    assign key_raw     = w_head.raw;
    assign key_ext     = w_head.ext;
    assign key_release = w_head.is_release;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keypad_rx.sv
//------------------------------------------------------------------------------
// Module   : tb_ps2_keypad_rx
// Brief    : Self-checking bench for ps2_keypad_rx with a byte-level token model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_keypad_rx;

    localparam int c_DEPTH = 4;
`ifdef PS2_BREAK_EVENTS_EN
    localparam bit c_BRK_EN = 1'b1;
`else
    localparam bit c_BRK_EN = 1'b0;
`endif
    localparam logic [7:0] c_SCAN [16] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C,
                                            8'h75, 8'h7D, 8'h79, 8'h7B, 8'h7C, 8'h4A, 8'h5A, 8'h76};

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic       key_ready = 1'b0;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] key_raw;
    logic       key_ext;
    logic       key_release;
    logic       frame_err;
    logic       overflow;
    logic [2:0] fifo_level;

    int total = 0;
    int bad = 0;
    int cyc;
    int rise_cyc = -1;
    int last_fall = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    logic pv = 1'b0;
    logic [13:0] exp_q[$];
    logic m_ext = 1'b0;
    logic m_brk = 1'b0;
    int m_ovf = 0;

    ps2_keypad_rx #(.CLK_DIV(4), .TIMEOUT_TICKS(20), .FIFO_DEPTH(c_DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .key_raw(key_raw), .key_ext(key_ext), .key_release(key_release),
        .frame_err(frame_err), .overflow(overflow), .fifo_level(fifo_level));

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge CLK) begin
        if (frame_err) err_cnt = err_cnt + 1;
        if (overflow)  ovf_cnt = ovf_cnt + 1;
        if (key_valid && !pv) rise_cyc = cyc;
        pv = key_valid;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int code_of(input logic [7:0] b);
        for (int i = 0; i < 16; i++) if (c_SCAN[i] == b) return i;
        return -1;
    endfunction

    // Reference: prefix rules and FIFO capacity applied to each accepted byte.
    task automatic model_byte(input logic [7:0] b);
        int c;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            c = code_of(b);
            if (c >= 0 && (!m_brk || c_BRK_EN)) begin
                if (exp_q.size() < c_DEPTH) exp_q.push_back({b, 4'(c), m_ext, m_brk & c_BRK_EN});
                else m_ovf++;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_bit(input logic b);
        @(negedge CLK);
        PS2_DATA = b;
        wait_cycles(10);
        PS2_CLK = 1'b0;
        last_fall = cyc + 1;
        wait_cycles(20);
        PS2_CLK = 1'b1;
        wait_cycles(10);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int n);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < n; i++) send_bit(f[i]);
        wait_cycles(10);
    endtask

    task automatic send_key(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
        model_byte(b);
    endtask

    task automatic drain(input string name);
        logic [13:0] e;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (!key_valid) break;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s extra token act=%h", name, {key_raw, key_code, key_ext, key_release});
            end else begin
                e = exp_q.pop_front();
                if ({key_raw, key_code, key_ext, key_release} !== e) begin
                    bad++;
                    $display("FAIL %s token act=%h exp=%h", name, {key_raw, key_code, key_ext, key_release}, e);
                end
            end
            key_ready = 1'b1;
            @(negedge CLK);
            key_ready = 1'b0;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s missing tokens act=0 exp=%0d", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if ({key_valid, key_code, key_raw, key_ext, key_release, frame_err, overflow, fifo_level} !== '0) begin
            bad++;
            $display("FAIL %s outputs act=%b exp=0", name,
                     {key_valid, key_code, key_raw, key_ext, key_release, frame_err, overflow, fifo_level});
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        wait_cycles(3);
        check_idle_outputs("reset");
        RST_N = 1'b1;
        wait_cycles(5);
        check_idle_outputs("post_reset");
    endtask

    task automatic test_single();
        int exp_rise;
        rise_cyc = -1;
        send_key(8'h69);
        exp_rise = ((last_fall + 2 + 3) / 4) * 4 + 2;
        total++;
        if (rise_cyc !== exp_rise) begin
            bad++;
            $display("FAIL latency act=%0d exp=%0d", rise_cyc, exp_rise);
        end
        total++;
        if ({key_valid, key_code, key_raw, key_ext} !== {1'b1, 4'd1, 8'h69, 1'b0}) begin
            bad++;
            $display("FAIL single act=%b/%0d/%h/%b exp=1/1/69/0", key_valid, key_code, key_raw, key_ext);
        end
        drain("single");
    endtask

    task automatic test_parity_err();
        int e0;
        e0 = err_cnt;
        send_bits(8'h72, 1'b1, 11);
        total++;
        if (err_cnt - e0 !== 1) begin
            bad++;
            $display("FAIL parity_err pulses act=%0d exp=1", err_cnt - e0);
        end
        total++;
        if ({key_valid, fifo_level} !== 4'd0) begin
            bad++;
            $display("FAIL parity_err token act=%b/%0d exp=0/0", key_valid, fifo_level);
        end
        send_key(8'h7A);
        total++;
        if (key_code !== 4'd3) begin
            bad++;
            $display("FAIL after_err code act=%0d exp=3", key_code);
        end
        drain("after_err");
    endtask

    task automatic test_prefix();
        send_key(8'hE0);
        send_key(8'h5A);
        total++;
        if ({key_valid, key_code, key_ext} !== {1'b1, 4'd14, 1'b1}) begin
            bad++;
            $display("FAIL ext_enter act=%b/%0d/%b exp=1/14/1", key_valid, key_code, key_ext);
        end
        drain("ext_enter");
        send_key(8'hF0);
        send_key(8'h69);
`ifdef PS2_BREAK_EVENTS_EN
        total++;
        if ({key_valid, key_code, key_release} !== {1'b1, 4'd1, 1'b1}) begin
            bad++;
            $display("FAIL break act=%b/%0d/%b exp=1/1/1", key_valid, key_code, key_release);
        end
`else
        total++;
        if ({key_valid, fifo_level} !== 4'd0) begin
            bad++;
            $display("FAIL break act=%b/%0d exp=0/0", key_valid, fifo_level);
        end
`endif
        drain("break");
    endtask

    task automatic test_overflow();
        int o0;
        int m0;
        logic [13:0] e;
        o0 = ovf_cnt;
        m0 = m_ovf;
        key_ready = 1'b0;
        send_key(8'h69);
        send_key(8'h72);
        send_key(8'h7A);
        send_key(8'h6B);
        send_key(8'h73);
        total++;
        if (fifo_level !== 3'(exp_q.size())) begin
            bad++;
            $display("FAIL ovf_level act=%0d exp=%0d", fifo_level, exp_q.size());
        end
        total++;
        if (ovf_cnt - o0 !== m_ovf - m0) begin
            bad++;
            $display("FAIL ovf_pulses act=%0d exp=%0d", ovf_cnt - o0, m_ovf - m0);
        end
        @(negedge CLK);
        key_ready = 1'b1;
        for (int i = 0; i < c_DEPTH; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 14'h0;
            total++;
            if ({key_valid, key_raw, key_code, key_ext, key_release} !== {1'b1, e}) begin
                bad++;
                $display("FAIL b2b_pop%0d act=%b/%h exp=1/%h", i, key_valid,
                         {key_raw, key_code, key_ext, key_release}, e);
            end
            @(negedge CLK);
        end
        key_ready = 1'b0;
        total++;
        if ({key_valid, fifo_level} !== 4'd0) begin
            bad++;
            $display("FAIL b2b_empty act=%b/%0d exp=0/0", key_valid, fifo_level);
        end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        send_bits(8'($urandom_range(0, 255)), 1'b0, 5);
        wait_cycles(110);
        total++;
        if ({key_valid, fifo_level} !== 4'd0 || err_cnt != e0) begin
            bad++;
            $display("FAIL timeout act=%b/%0d/%0d exp=0/0/0", key_valid, fifo_level, err_cnt - e0);
        end
        send_key(8'h70);
        total++;
        if ({key_valid, key_code} !== {1'b1, 4'd0}) begin
            bad++;
            $display("FAIL after_timeout act=%b/%0d exp=1/0", key_valid, key_code);
        end
        drain("after_timeout");
    endtask

    task automatic test_random();
        int e0;
        int exp_err;
        int kind;
        logic [7:0] b;
        e0 = err_cnt;
        exp_err = 0;
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 9);
            b = c_SCAN[$urandom_range(0, 15)];
            if (kind == 6) b = 8'hE0;
            else if (kind == 7) b = 8'hF0;
            else if (kind == 8) begin
                for (int k = 0; k < 50; k++) begin
                    b = 8'($urandom_range(0, 255));
                    if (code_of(b) < 0 && b != 8'hE0 && b != 8'hF0) break;
                end
            end
            if (kind == 9) begin
                send_bits(b, 1'b1, 11);
                exp_err++;
            end else begin
                send_key(b);
            end
            drain("random");
        end
        total++;
        if (err_cnt - e0 != exp_err) begin
            bad++;
            $display("FAIL random_err act=%0d exp=%0d", err_cnt - e0, exp_err);
        end
    endtask

    task automatic test_reset_mid();
        key_ready = 1'b0;
        send_key(8'h69);
        send_key(8'h72);
        total++;
        if (fifo_level !== 3'(exp_q.size())) begin
            bad++;
            $display("FAIL pre_reset_level act=%0d exp=%0d", fifo_level, exp_q.size());
        end
        send_bits(8'hF0, 1'b0, 11);
        send_bits(8'h75, 1'b0, 6);
        @(negedge CLK);
        RST_N = 1'b0;
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        wait_cycles(2);
        check_idle_outputs("mid_reset");
        RST_N = 1'b1;
        wait_cycles(20);
        send_key(8'h76);
        total++;
        if ({key_valid, key_code, key_ext, key_release} !== {1'b1, 4'd15, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL after_reset act=%b/%0d/%b/%b exp=1/15/0/0", key_valid, key_code, key_ext, key_release);
        end
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity_err();
        test_prefix();
        test_overflow();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
